ship_bullet_unit: RTL and testbench

Player-side game logic for the Space Invaders core: it debounces the four player buttons, keeps the ship's column on the playfield, and owns the single player bullet. It sits between the raw button pins and the renderer/collision logic, and runs on the 36 MHz pixel clock. All motion is paced by the `enable` game-tick strobe.

---
 rtl/ship_bullet_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_ship_bullet_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_bullet_unit.sv
// ship_bullet_unit: player-side game logic for the Space Invaders core.
// Debounces the four player buttons, keeps the ship column on the playfield
// and owns the single player bullet.
//
// Ports:
//   clk_36MHz       in   pixel clock, all flops on the rising edge
//   reset           in   asynchronous active-low reset
//   enable          in   game-tick strobe, paces sampling and bullet motion
//   left/right      in   raw ship-move buttons
//   start           in   raw start button, exported only as a pulse
//   shoot           in   raw fire button
//   hit             in   one-cycle pulse: the bullet struck something
//   ship_x          out  ship column (0..COLS-1)
//   start_debounced out  one-cycle pulse per accepted start press
//   bullet_x        out  bullet column, fixed for the whole flight
//   bullet_y        out  bullet row
//   bullet_flying   out  bullet is active

// ---------------------------------------------------------------------------
// ship_bullet_debounce: 2-flop synchronizer, enable-sampled history and a
// one-clock pulse on each accepted press.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   enable  in   sampling strobe
//   din     in   raw asynchronous input
//   pulse   out  registered one-clock pulse per 0->1 of the stable state
// ---------------------------------------------------------------------------
module ship_bullet_debounce #(
    parameter int unsigned SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic din,
    output logic pulse
);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [SAMPLES-1:0] hist_q,  hist_d;
    logic               stable_q, stable_d;
    logic               pulse_q, pulse_d;

    // Next-state: stable state and pulse look at the history as it will be
    // after this edge, so the pulse lands in the cycle after the last sample.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        hist_d   = hist_q;
        if (enable) begin
            hist_d = (hist_q << 1) | SAMPLES'(sync2_q);
        end
        stable_d = stable_q;
        if (&hist_d) begin
            stable_d = 1'b1;
        end else if (~|hist_d) begin
            stable_d = 1'b0;
        end
        pulse_d  = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= '0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            hist_q   <= hist_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// ---------------------------------------------------------------------------
// ship_bullet_unit top
// ---------------------------------------------------------------------------
module ship_bullet_unit #(
    parameter  int unsigned COLS             = 20,
    parameter  int unsigned ROWS             = 15,
    parameter  int unsigned SHIP_X_RESET     = 10,
    parameter  int unsigned DEBOUNCE_SAMPLES = 3,
    localparam int unsigned X_W              = 5,
    localparam int unsigned Y_W              = 4
) (
    input  logic           clk_36MHz,
    input  logic           reset,
    input  logic           enable,
    input  logic           left,
    input  logic           right,
    input  logic           start,
    input  logic           shoot,
    input  logic           hit,
    output logic [X_W-1:0] ship_x,
    output logic           start_debounced,
    output logic [X_W-1:0] bullet_x,
    output logic [Y_W-1:0] bullet_y,
    output logic           bullet_flying
);

    localparam logic [X_W-1:0] X_MAX     = X_W'(COLS - 1);
    localparam logic [X_W-1:0] X_RESET   = X_W'(SHIP_X_RESET);
    localparam logic [Y_W-1:0] Y_LAUNCH  = Y_W'(ROWS - 2);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_FLYING = 1'b1
    } state_t;

    logic left_p, right_p, start_p, shoot_p;

    state_t         state_q, state_d;
    logic [X_W-1:0] ship_x_q, ship_x_d;
    logic [X_W-1:0] bullet_x_q, bullet_x_d;
    logic [Y_W-1:0] bullet_y_q, bullet_y_d;

    // Button conditioning
    ship_bullet_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_db_left (
        .clk    (clk_36MHz),
        .rst_n  (reset),
        .enable (enable),
        .din    (left),
        .pulse  (left_p)
    );

    ship_bullet_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_db_right (
        .clk    (clk_36MHz),
        .rst_n  (reset),
        .enable (enable),
        .din    (right),
        .pulse  (right_p)
    );

    ship_bullet_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_db_start (
        .clk    (clk_36MHz),
        .rst_n  (reset),
        .enable (enable),
        .din    (start),
        .pulse  (start_p)
    );

    ship_bullet_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_db_shoot (
        .clk    (clk_36MHz),
        .rst_n  (reset),
        .enable (enable),
        .din    (shoot),
        .pulse  (shoot_p)
    );

    // Ship column: saturating move, simultaneous left+right cancels
    always_comb begin
        ship_x_d = ship_x_q;
        if (left_p && !right_p && (ship_x_q != '0)) begin
            ship_x_d = ship_x_q - X_W'(1);
        end else if (right_p && !left_p && (ship_x_q != X_MAX)) begin
            ship_x_d = ship_x_q + X_W'(1);
        end
    end

    // Bullet FSM: state register
    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bullet FSM: next state; hit outranks both launch and motion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (shoot_p && !hit) begin
                    state_d = S_FLYING;
                end
            end
            S_FLYING: begin
                if (hit) begin
                    state_d = S_IDLE;
                end else if (enable && (bullet_y_q == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bullet FSM: position; coordinates hold whenever idle or on a hit
    always_comb begin
        bullet_x_d = bullet_x_q;
        bullet_y_d = bullet_y_q;
        case (state_q)
            S_IDLE: begin
                if (shoot_p && !hit) begin
                    bullet_x_d = ship_x_q;
                    bullet_y_d = Y_LAUNCH;
                end
            end
            S_FLYING: begin
                if (!hit && enable && (bullet_y_q != '0)) begin
                    bullet_y_d = bullet_y_q - Y_W'(1);
                end
            end
            default: begin
                bullet_x_d = bullet_x_q;
                bullet_y_d = bullet_y_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            ship_x_q   <= X_RESET;
            bullet_x_q <= '0;
            bullet_y_q <= '0;
        end else begin
            ship_x_q   <= ship_x_d;
            bullet_x_q <= bullet_x_d;
            bullet_y_q <= bullet_y_d;
        end
    end

    assign ship_x          = ship_x_q;
    assign bullet_x        = bullet_x_q;
    assign bullet_y        = bullet_y_q;
    assign bullet_flying   = (state_q == S_FLYING);
    assign start_debounced = start_p;

endmodule

// File: tb/tb_ship_bullet_unit.sv
// Scoreboard bench for ship_bullet_unit: stimulus pushes hand-computed
// expected outputs, a negedge monitor pops and compares them.
module tb_ship_bullet_unit;

    logic       clk_36MHz = 1'b0;
    logic       reset     = 1'b0;
    logic       enable    = 1'b0;
    logic       left      = 1'b0;
    logic       right     = 1'b0;
    logic       start     = 1'b0;
    logic       shoot     = 1'b0;
    logic       hit       = 1'b0;
    logic [4:0] ship_x;
    logic       start_debounced;
    logic [4:0] bullet_x;
    logic [3:0] bullet_y;
    logic       bullet_flying;

    ship_bullet_unit dut (
        .clk_36MHz       (clk_36MHz),
        .reset           (reset),
        .enable          (enable),
        .left            (left),
        .right           (right),
        .start           (start),
        .shoot           (shoot),
        .hit             (hit),
        .ship_x          (ship_x),
        .start_debounced (start_debounced),
        .bullet_x        (bullet_x),
        .bullet_y        (bullet_y),
        .bullet_flying   (bullet_flying)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    typedef struct packed {
        logic [4:0] ship;
        logic [4:0] bx;
        logic [3:0] by;
        logic       fly;
        logic [7:0] starts;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    start_seen  = 0;

    // Monitor: counts start pulses, then checks every queued expectation
    always @(negedge clk_36MHz) begin : monitor
        exp_t  e;
        string n;
        if (start_debounced) start_seen++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (ship_x !== e.ship || bullet_x !== e.bx || bullet_y !== e.by ||
                bullet_flying !== e.fly || start_seen != int'(e.starts)) begin
                miscompares++;
                $display("FAIL %s: got ship_x=%0d bullet_x=%0d bullet_y=%0d flying=%0b starts=%0d, expected ship_x=%0d bullet_x=%0d bullet_y=%0d flying=%0b starts=%0d",
                         n, ship_x, bullet_x, bullet_y, bullet_flying, start_seen,
                         e.ship, e.bx, e.by, e.fly, e.starts);
            end
        end
    end

    task automatic expect_now(input string n, input int s, input int bx,
                              input int by, input int fly, input int st);
        exp_t e;
        e.ship   = 5'(s);
        e.bx     = 5'(bx);
        e.by     = 4'(by);
        e.fly    = 1'(fly);
        e.starts = 8'(st);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_36MHz);
            #1;
        end
    endtask

    task automatic en_strobe();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(1);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       left  = v;
            1:       right = v;
            2:       start = v;
            default: shoot = v;
        endcase
    endtask

    // Press and hold until the debounced pulse has been consumed; optional
    // hit coincides with the pulse cycle.
    task automatic hold(input int b, input logic with_hit);
        set_btn(b, 1'b1);
        tick(3);
        en_strobe();
        en_strobe();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        hit    = with_hit;
        tick(1);
        hit    = 1'b0;
    endtask

    task automatic rel(input int b);
        set_btn(b, 1'b0);
        tick(3);
        repeat (3) en_strobe();
    endtask

    initial begin : stim
        int s;
        tick(3);
        expect_now("reset_state", 10, 0, 0, 0, 0);
        tick(1);
        reset = 1'b1;
        tick(2);

        // Debounce
        hold(1, 1'b0);
        expect_now("right_press", 11, 0, 0, 0, 0);
        repeat (20) en_strobe();
        expect_now("right_held", 11, 0, 0, 0, 0);
        rel(1);

        left = 1'b1; tick(3); en_strobe(); left = 1'b0; tick(3);
        repeat (3) en_strobe();
        expect_now("left_glitch_1", 11, 0, 0, 0, 0);
        left = 1'b1; tick(3); en_strobe(); en_strobe(); left = 1'b0; tick(3);
        repeat (3) en_strobe();
        expect_now("left_glitch_2", 11, 0, 0, 0, 0);

        // Saturation
        s = 11;
        for (int i = 1; i <= 12; i++) begin
            hold(0, 1'b0);
            rel(0);
            s = (s > 0) ? s - 1 : 0;
            if (i == 11) expect_now("left_to_zero", 0, 0, 0, 0, 0);
            if (i == 12) expect_now("left_saturate", s, 0, 0, 0, 0);
        end
        for (int i = 1; i <= 25; i++) begin
            hold(1, 1'b0);
            rel(1);
            if (i == 19) expect_now("right_to_edge", 19, 0, 0, 0, 0);
            if (i == 25) expect_now("right_saturate", 19, 0, 0, 0, 0);
        end
        repeat (12) begin
            hold(0, 1'b0);
            rel(0);
        end
        expect_now("ship_at_7", 7, 0, 0, 0, 0);

        // Flight
        hold(3, 1'b0);
        expect_now("launch", 7, 7, 13, 1, 0);
        rel(3);
        expect_now("flight_3", 7, 7, 10, 1, 0);
        hold(3, 1'b0);
        rel(3);
        expect_now("second_shoot_ignored", 7, 7, 4, 1, 0);
        hold(1, 1'b0);
        expect_now("ship_moves_in_flight", 8, 7, 1, 1, 0);
        right = 1'b0;
        tick(3);
        en_strobe();
        expect_now("reach_top", 8, 7, 0, 1, 0);
        en_strobe();
        expect_now("leave_screen", 8, 7, 0, 0, 0);
        en_strobe();
        expect_now("idle_holds", 8, 7, 0, 0, 0);

        // Hit
        hold(3, 1'b0);
        expect_now("launch2", 8, 8, 13, 1, 0);
        rel(3);
        repeat (5) en_strobe();
        expect_now("at_row5", 8, 8, 5, 1, 0);
        hit = 1'b1; enable = 1'b1; tick(1);
        hit = 1'b0; enable = 1'b0; tick(1);
        expect_now("hit_with_enable", 8, 8, 5, 0, 0);
        hold(0, 1'b0);
        rel(0);
        expect_now("ship_left_after_hit", 7, 8, 5, 0, 0);
        hold(3, 1'b0);
        expect_now("relaunch", 7, 7, 13, 1, 0);
        hit = 1'b1; tick(1); hit = 1'b0; tick(1);
        expect_now("hit_no_enable", 7, 7, 13, 0, 0);
        rel(3);
        hit = 1'b1; tick(1); hit = 1'b0; tick(1);
        expect_now("hit_while_idle", 7, 7, 13, 0, 0);
        hold(3, 1'b1);
        expect_now("hit_beats_shoot", 7, 7, 13, 0, 0);
        rel(3);

        // Start
        hold(2, 1'b0);
        expect_now("start_pulse", 7, 7, 13, 0, 1);
        repeat (5) en_strobe();
        expect_now("start_held", 7, 7, 13, 0, 1);
        rel(2);
        hold(2, 1'b0);
        rel(2);
        expect_now("start_second", 7, 7, 13, 0, 2);

        // Asynchronous reset mid-flight and mid-debounce
        hold(3, 1'b0);
        shoot = 1'b0;
        right = 1'b1;
        tick(3);
        en_strobe();
        expect_now("pre_reset", 7, 7, 12, 1, 2);
        tick(1);
        reset = 1'b0;
        #1;
        expect_now("async_reset", 10, 0, 0, 0, 2);
        tick(2);
        reset = 1'b1;
        tick(3);
        expect_now("no_pulse_at_release", 10, 0, 0, 0, 2);
        en_strobe();
        en_strobe();
        expect_now("two_samples_after_reset", 10, 0, 0, 0, 2);
        en_strobe();
        expect_now("full_sequence_after_reset", 11, 0, 0, 0, 2);
        tick(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(1);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
